sync_meas_counter: RTL and testbench

Measurement counter that sits directly downstream of the SDR_SYNC edge-qualifying state machine and consumes its E (enable), L (load) and U_D (direction) strobes. It counts CLK cycles for as long as the window is enabled. On the falling edge of E it captures the final count into a hold register. It then presents the result to the sync/control logic through a valid/ack handshake, with saturation and overrun reporting.

---
 rtl/sync_meas_counter_if.sv | 31 +++
 rtl/sync_meas_counter.sv | 103 ++++++++++
 tb/tb_sync_meas_counter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sync_meas_counter_if.sv
// Strobe / result bundle between the SDR_SYNC state machine, the
// measurement counter and the consumer of the captured result.
interface sync_meas_counter_if #(
  parameter int WIDTH = 32,
  parameter int SEQ_W = 8
);
  logic             E;
  logic             L;
  logic             U_D;
  logic             meas_ack;
  logic [WIDTH-1:0] count_o;
  logic [WIDTH-1:0] meas_o;
  logic             meas_valid;
  logic [SEQ_W-1:0] meas_seq;
  logic             sat;
  logic             meas_sat;
  logic             overrun;
  logic             busy;

  // Driver side: state machine strobes plus the result consumer's ack.
  modport master (
    output E, L, U_D, meas_ack,
    input  count_o, meas_o, meas_valid, meas_seq, sat, meas_sat, overrun, busy
  );

  // Counter side.
  modport slave (
    input  E, L, U_D, meas_ack,
    output count_o, meas_o, meas_valid, meas_seq, sat, meas_sat, overrun, busy
  );
endinterface

// File: rtl/sync_meas_counter.sv
// Saturating up/down window counter. Counts while E is high, captures the
// final count on E's falling edge and offers it through a valid/ack
// handshake with a sequence number and a sticky overrun flag.
module sync_meas_counter #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] LOAD_VAL = '0,
  parameter int               SEQ_W    = 8
) (
  input  logic              CLK,
  input  logic              RSET,
  sync_meas_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             e_d_q, e_d_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] meas_o_q, meas_o_d;
  logic             meas_valid_q, meas_valid_d;
  logic [SEQ_W-1:0] meas_seq_q, meas_seq_d;
  logic             meas_sat_q, meas_sat_d;
  logic             overrun_q, overrun_d;
  logic             capture;

  // Falling E is a capture even when L rises in the same cycle: the
  // window's count (pre-load value) is what gets captured.
  assign capture = e_d_q & ~bus.E;

  // Next-state: counter with load priority, capture and handshake.
  always_comb begin
    cnt_d        = cnt_q;
    sat_d        = sat_q;
    e_d_d        = bus.E;
    busy_d       = bus.E;
    meas_o_d     = meas_o_q;
    meas_valid_d = meas_valid_q;
    meas_seq_d   = meas_seq_q;
    meas_sat_d   = meas_sat_q;
    overrun_d    = overrun_q;

    if (bus.L) begin
      cnt_d = LOAD_VAL;
      sat_d = 1'b0;
    end else if (bus.E) begin
      if (bus.U_D) begin
        if (cnt_q == CNT_MAX) sat_d = 1'b1;
        else                  cnt_d = cnt_q + WIDTH'(1);
      end else begin
        if (cnt_q == '0) sat_d = 1'b1;
        else             cnt_d = cnt_q - WIDTH'(1);
      end
    end

    if (capture) begin
      // A same-cycle ack frees the slot, so the new sample is accepted.
      if (!meas_valid_q || bus.meas_ack) begin
        meas_o_d     = cnt_q;
        meas_sat_d   = sat_q;
        meas_valid_d = 1'b1;
        meas_seq_d   = meas_seq_q + SEQ_W'(1);
      end else begin
        overrun_d = 1'b1;
      end
    end else if (meas_valid_q && bus.meas_ack) begin
      meas_valid_d = 1'b0;
    end
  end

  // State register; reset forces e_d low so no capture comes from reset.
  always_ff @(posedge CLK) begin
    if (RSET) begin
      cnt_q        <= LOAD_VAL;
      sat_q        <= 1'b0;
      e_d_q        <= 1'b0;
      busy_q       <= 1'b0;
      meas_o_q     <= '0;
      meas_valid_q <= 1'b0;
      meas_seq_q   <= '0;
      meas_sat_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
      e_d_q        <= e_d_d;
      busy_q       <= busy_d;
      meas_o_q     <= meas_o_d;
      meas_valid_q <= meas_valid_d;
      meas_seq_q   <= meas_seq_d;
      meas_sat_q   <= meas_sat_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.count_o    = cnt_q;
  assign bus.sat        = sat_q;
  assign bus.busy       = busy_q;
  assign bus.meas_o     = meas_o_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.meas_seq   = meas_seq_q;
  assign bus.meas_sat   = meas_sat_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_sync_meas_counter.sv
// Three counters (32-bit/load 0, 4-bit/load 14, 4-bit/load 3) share one
// stimulus stream; each is checked every cycle against a plain model.
module tb_sync_meas_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic e = 1'b0, l = 1'b0, ud = 1'b1, ack = 1'b0;
  int   vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  sync_meas_counter_if #(.WIDTH(32), .SEQ_W(8)) if0 ();
  sync_meas_counter_if #(.WIDTH(4),  .SEQ_W(8)) if1 ();
  sync_meas_counter_if #(.WIDTH(4),  .SEQ_W(8)) if2 ();

  assign if0.E = e;  assign if0.L = l;  assign if0.U_D = ud;  assign if0.meas_ack = ack;
  assign if1.E = e;  assign if1.L = l;  assign if1.U_D = ud;  assign if1.meas_ack = ack;
  assign if2.E = e;  assign if2.L = l;  assign if2.U_D = ud;  assign if2.meas_ack = ack;

  sync_meas_counter #(.WIDTH(32), .LOAD_VAL(32'd0), .SEQ_W(8)) dut0 (.CLK(clk), .RSET(rst), .bus(if0));
  sync_meas_counter #(.WIDTH(4),  .LOAD_VAL(4'd14), .SEQ_W(8)) dut1 (.CLK(clk), .RSET(rst), .bus(if1));
  sync_meas_counter #(.WIDTH(4),  .LOAD_VAL(4'd3),  .SEQ_W(8)) dut2 (.CLK(clk), .RSET(rst), .bus(if2));

  // ---------------- behavioural model ----------------
  localparam logic [31:0] MAXV [3] = '{32'hFFFF_FFFF, 32'd15, 32'd15};
  localparam logic [31:0] LDV  [3] = '{32'd0, 32'd14, 32'd3};
  logic [31:0] m_cnt [3];
  logic [31:0] m_mo  [3];
  logic [7:0]  m_seq [3];
  bit m_sat[3], m_msat[3], m_mv[3], m_ovr[3], m_busy[3], m_prev_e[3];
  bit model_ok = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_cnt[k] = LDV[k]; m_sat[k] = 0; m_mo[k] = 0; m_seq[k] = 0;
        m_msat[k] = 0; m_mv[k] = 0; m_ovr[k] = 0; m_busy[k] = 0; m_prev_e[k] = 0;
      end else begin
        logic [31:0] nc; bit ns;
        nc = m_cnt[k]; ns = m_sat[k];
        if (l) begin nc = LDV[k]; ns = 0; end
        else if (e && ud)  begin if (m_cnt[k] == MAXV[k]) ns = 1; else nc = m_cnt[k] + 1; end
        else if (e && !ud) begin if (m_cnt[k] == 0) ns = 1; else nc = m_cnt[k] - 1; end
        if (m_prev_e[k] && !e) begin
          if (!m_mv[k] || ack) begin
            m_mo[k] = m_cnt[k]; m_msat[k] = m_sat[k]; m_mv[k] = 1; m_seq[k] = m_seq[k] + 8'd1;
          end else m_ovr[k] = 1;
        end else if (ack) m_mv[k] = 0;
        m_cnt[k] = nc; m_sat[k] = ns; m_prev_e[k] = e; m_busy[k] = e;
      end
    end
    if (rst) model_ok = 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [31:0] cnt, mo, input logic mv,
                          input logic [7:0] seq, input logic sat, msat, ovr, busy);
    string p;
    p = $sformatf("dut%0d.", k);
    chk({p, "count_o"},    cnt,  m_cnt[k]);
    chk({p, "meas_o"},     mo,   m_mo[k]);
    chk({p, "meas_valid"}, {31'd0, mv},   {31'd0, m_mv[k]});
    chk({p, "meas_seq"},   {24'd0, seq},  {24'd0, m_seq[k]});
    chk({p, "sat"},        {31'd0, sat},  {31'd0, m_sat[k]});
    chk({p, "meas_sat"},   {31'd0, msat}, {31'd0, m_msat[k]});
    chk({p, "overrun"},    {31'd0, ovr},  {31'd0, m_ovr[k]});
    chk({p, "busy"},       {31'd0, busy}, {31'd0, m_busy[k]});
  endtask

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      cmp_inst(0, if0.count_o, if0.meas_o, if0.meas_valid, if0.meas_seq,
               if0.sat, if0.meas_sat, if0.overrun, if0.busy);
      cmp_inst(1, {28'd0, if1.count_o}, {28'd0, if1.meas_o}, if1.meas_valid, if1.meas_seq,
               if1.sat, if1.meas_sat, if1.overrun, if1.busy);
      cmp_inst(2, {28'd0, if2.count_o}, {28'd0, if2.meas_o}, if2.meas_valid, if2.meas_seq,
               if2.sat, if2.meas_sat, if2.overrun, if2.busy);
    end
  end

  // Apply one input set for n clock edges; returns 2 time units after the last edge.
  task automatic step(input bit ee, ll, uu, aa, rr, input int n = 1);
    for (int i = 0; i < n; i++) begin
      e = ee; l = ll; ud = uu; ack = aa; rst = rr;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    // reset state
    step(0, 0, 1, 0, 1, 2);
    chk("rst count0", if0.count_o, 0);
    chk("rst count1", {28'd0, if1.count_o}, 14);
    chk("rst valid0", {31'd0, if0.meas_valid}, 0);
    chk("rst seq0",   {24'd0, if0.meas_seq}, 0);

    // 100-cycle up window
    step(0, 1, 1, 0, 0, 3);
    step(1, 0, 1, 0, 0, 100);
    chk("busy during window", {31'd0, if0.busy}, 1);
    step(0, 0, 1, 0, 0);
    chk("win100 meas_o",   if0.meas_o, 100);
    chk("win100 valid",    {31'd0, if0.meas_valid}, 1);
    chk("win100 seq",      {24'd0, if0.meas_seq}, 1);
    chk("win100 meas_sat", {31'd0, if0.meas_sat}, 0);
    chk("win100 count",    if0.count_o, 100);
    chk("win100 busy",     {31'd0, if0.busy}, 0);
    step(0, 0, 1, 1, 0);
    chk("ack clears valid", {31'd0, if0.meas_valid}, 0);
    step(0, 0, 1, 1, 0);
    chk("idle ack seq", {24'd0, if0.meas_seq}, 1);

    // 4-bit up saturation from 14
    step(0, 1, 1, 0, 0, 2);
    step(1, 0, 1, 0, 0);
    chk("sat1 count", {28'd0, if1.count_o}, 15);
    chk("sat1 sat",   {31'd0, if1.sat}, 0);
    step(1, 0, 1, 0, 0);
    chk("sat2 count", {28'd0, if1.count_o}, 15);
    chk("sat2 sat",   {31'd0, if1.sat}, 1);
    step(1, 0, 1, 0, 0, 3);
    step(0, 0, 1, 0, 0);
    chk("sat meas_o",   {28'd0, if1.meas_o}, 15);
    chk("sat meas_sat", {31'd0, if1.meas_sat}, 1);
    step(0, 1, 1, 1, 0);
    chk("load clears sat", {31'd0, if1.sat}, 0);

    // down windows from 3
    step(1, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0);
    chk("down2 meas_o", {28'd0, if2.meas_o}, 1);
    step(0, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 6);
    step(0, 0, 0, 0, 0);
    chk("down6 meas_o",   {28'd0, if2.meas_o}, 0);
    chk("down6 meas_sat", {31'd0, if2.meas_sat}, 1);

    // overrun: two windows, no ack
    step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 3);
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 5);
    step(0, 0, 1, 0, 0);
    chk("ovr meas_o",  if0.meas_o, 3);
    chk("ovr seq",     {24'd0, if0.meas_seq}, 1);
    chk("ovr overrun", {31'd0, if0.overrun}, 1);

    // same again, acked on the second capture cycle
    step(0, 0, 1, 0, 1);
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 3);
    step(0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0, 5);
    step(0, 0, 1, 1, 0);
    chk("b2b meas_o",  if0.meas_o, 5);
    chk("b2b valid",   {31'd0, if0.meas_valid}, 1);
    chk("b2b seq",     {24'd0, if0.meas_seq}, 2);
    chk("b2b overrun", {31'd0, if0.overrun}, 0);

    // reset mid-window at 37
    step(0, 1, 1, 1, 0);
    step(1, 0, 1, 0, 0, 37);
    chk("pre-rst count", if0.count_o, 37);
    step(1, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("mid-rst count", if0.count_o, 0);
    chk("mid-rst valid", {31'd0, if0.meas_valid}, 0);
    chk("mid-rst seq",   {24'd0, if0.meas_seq}, 0);
    chk("mid-rst ovr",   {31'd0, if0.overrun}, 0);

    // randomized traffic
    begin
      bit re, rl, ru;
      re = 0; ru = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) re = ~re;
        if ($urandom_range(0, 11) == 0) ru = ~ru;
        rl = re ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
        step(re, rl, ru, $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
